seq_alu: RTL and testbench

Parametrised, handshaked successor to the 16-bit combinational ALU in the datapath. Single-cycle ops complete in one clock. Shifts run iteratively at one bit per cycle, and the optional multiply runs as a shift-add sequence. The block sits between the register-file read stage and write-back, and each result is held until write-back accepts it.

---
 rtl/seq_alu.sv | 222 ++++++++++++++++++++++
 tb/tb_seq_alu.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Handshaked sequential ALU: single-cycle ops, iterative 1-bit/cycle shifts,
// and an optional shift-add multiplier enabled by SEQ_ALU_MUL_EN.
module seq_alu #(
  parameter int WIDTH = 16,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  input  logic [2:0]       Alu_Opcode,
  input  logic             Shift,
  output logic [WIDTH-1:0] Result,
  output logic             Zero_Out,
  output logic             Carry_Out,
  output logic             Overflow_Out,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic             Busy
);

  localparam logic [SHW-1:0]   CNT_ZERO = {SHW{1'b0}};
  localparam logic [SHW-1:0]   CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};
  localparam logic [SHW-1:0]   CNT_ALL  = {SHW{1'b1}};
  localparam logic [WIDTH-1:0] RES_ZERO = {WIDTH{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
`ifdef SEQ_ALU_MUL_EN
    , ST_MUL = 2'd3
`endif
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [WIDTH-1:0] result_r;
  logic             zero_r, carry_r, ovf_r;
  logic [SHW-1:0]   cnt_r;
  logic [1:0]       kind_r;
  logic             accept_s;
  logic [WIDTH:0]   add_s, sub_s;
  logic [WIDTH-1:0] alu_res_s, sh_res_s;
  logic             alu_c_s, alu_v_s, sh_c_s;
`ifdef SEQ_ALU_MUL_EN
  logic [WIDTH-1:0] mcand_r, mplier_r, mul_acc_s;
`endif

  assign accept_s     = In_Valid && (state_r == ST_IDLE);
  assign In_Ready     = (state_r == ST_IDLE);
  assign Busy         = (state_r != ST_IDLE);
  assign Out_Valid    = (state_r == ST_DONE);
  assign Result       = result_r;
  assign Zero_Out     = zero_r;
  assign Carry_Out    = carry_r;
  assign Overflow_Out = ovf_r;

  // State register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!accept_s) begin
          state_nxt_s = ST_IDLE;
        end else if (Shift && (Operand2[SHW-1:0] != CNT_ZERO)) begin
          state_nxt_s = ST_SHIFT;
        end
`ifdef SEQ_ALU_MUL_EN
        else if (!Shift && (Alu_Opcode == 3'b111)) begin
          state_nxt_s = ST_MUL;
        end
`endif
        else begin
          state_nxt_s = ST_DONE;
        end
      end
      ST_SHIFT: begin
        if (cnt_r == CNT_ONE) state_nxt_s = ST_DONE;
        else                  state_nxt_s = ST_SHIFT;
      end
`ifdef SEQ_ALU_MUL_EN
      ST_MUL: begin
        if (cnt_r == CNT_ZERO) state_nxt_s = ST_DONE;
        else                   state_nxt_s = ST_MUL;
      end
`endif
      ST_DONE: begin
        if (Out_Ready) state_nxt_s = ST_IDLE;
        else           state_nxt_s = ST_DONE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Single-cycle result; a shift loads Operand1 as its starting value
  always_comb begin
    add_s     = {1'b0, Operand1} + {1'b0, Operand2};
    sub_s     = {1'b0, Operand1} + {1'b0, ~Operand2} + {{WIDTH{1'b0}}, 1'b1};
    alu_res_s = RES_ZERO;
    alu_c_s   = 1'b0;
    alu_v_s   = 1'b0;
    if (Shift) begin
      alu_res_s = Operand1;
    end else begin
      case (Alu_Opcode)
        3'b000: begin
          alu_res_s = add_s[WIDTH-1:0];
          alu_c_s   = add_s[WIDTH];
          alu_v_s   = (Operand1[WIDTH-1] == Operand2[WIDTH-1]) &&
                      (add_s[WIDTH-1] != Operand1[WIDTH-1]);
        end
        3'b001: begin
          alu_res_s = sub_s[WIDTH-1:0];
          alu_c_s   = sub_s[WIDTH];
          alu_v_s   = (Operand1[WIDTH-1] != Operand2[WIDTH-1]) &&
                      (sub_s[WIDTH-1] != Operand1[WIDTH-1]);
        end
        3'b010:  alu_res_s = Operand1 & Operand2;
        3'b011:  alu_res_s = Operand1 | Operand2;
        3'b100:  alu_res_s = Operand1 ^ Operand2;
        3'b101:  alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(Operand1) < $signed(Operand2))};
        3'b110:  alu_res_s = {{(WIDTH-1){1'b0}}, (Operand1 < Operand2)};
        default: alu_res_s = RES_ZERO;
      endcase
    end
  end

  // One-bit shift step; carry is the bit leaving the word
  always_comb begin
    sh_res_s = result_r;
    sh_c_s   = 1'b0;
    case (kind_r)
      2'b00: begin
        sh_res_s = {result_r[WIDTH-2:0], 1'b0};
        sh_c_s   = result_r[WIDTH-1];
      end
      2'b01: begin
        sh_res_s = {1'b0, result_r[WIDTH-1:1]};
        sh_c_s   = result_r[0];
      end
      2'b10: begin
        sh_res_s = {result_r[WIDTH-1], result_r[WIDTH-1:1]};
        sh_c_s   = result_r[0];
      end
      default: begin
        sh_res_s = {result_r[WIDTH-2:0], result_r[WIDTH-1]};
        sh_c_s   = result_r[WIDTH-1];
      end
    endcase
  end

`ifdef SEQ_ALU_MUL_EN
  // Shift-add partial product for the current multiplier bit
  always_comb begin
    if (mplier_r[0]) mul_acc_s = result_r + mcand_r;
    else             mul_acc_s = result_r;
  end
`endif

  // Datapath registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      result_r <= RES_ZERO;
      zero_r   <= 1'b1;
      carry_r  <= 1'b0;
      ovf_r    <= 1'b0;
      cnt_r    <= CNT_ZERO;
      kind_r   <= 2'b00;
`ifdef SEQ_ALU_MUL_EN
      mcand_r  <= RES_ZERO;
      mplier_r <= RES_ZERO;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            result_r <= alu_res_s;
            zero_r   <= (alu_res_s == RES_ZERO);
            carry_r  <= alu_c_s;
            ovf_r    <= alu_v_s;
            kind_r   <= Alu_Opcode[1:0];
            cnt_r    <= Shift ? Operand2[SHW-1:0] : CNT_ALL;
`ifdef SEQ_ALU_MUL_EN
            mcand_r  <= Operand1;
            mplier_r <= Operand2;
`endif
          end
        end
        ST_SHIFT: begin
          result_r <= sh_res_s;
          zero_r   <= (sh_res_s == RES_ZERO);
          carry_r  <= sh_c_s;
          cnt_r    <= cnt_r - CNT_ONE;
        end
`ifdef SEQ_ALU_MUL_EN
        ST_MUL: begin
          result_r <= mul_acc_s;
          zero_r   <= (mul_acc_s == RES_ZERO);
          mcand_r  <= {mcand_r[WIDTH-2:0], 1'b0};
          mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
          cnt_r    <= cnt_r - CNT_ONE;
        end
`endif
        default: begin
          result_r <= result_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu (WIDTH=16); follows SEQ_ALU_MUL_EN.
module tb_seq_alu;

  logic        Clk, Reset_n, In_Valid, In_Ready, Shift;
  logic [15:0] Operand1, Operand2, Result;
  logic [2:0]  Alu_Opcode;
  logic        Zero_Out, Carry_Out, Overflow_Out, Out_Valid, Out_Ready, Busy;
  int          n_checks, n_fail;

  seq_alu #(.WIDTH(16)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .In_Valid(In_Valid), .In_Ready(In_Ready),
    .Operand1(Operand1), .Operand2(Operand2), .Alu_Opcode(Alu_Opcode),
    .Shift(Shift), .Result(Result), .Zero_Out(Zero_Out), .Carry_Out(Carry_Out),
    .Overflow_Out(Overflow_Out), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
    .Busy(Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_res"},  {16'h0000, Result}, 32'h0000_0000);
    check_val({tag, "_z"},    {31'h0, Zero_Out}, 32'h1);
    check_val({tag, "_c"},    {31'h0, Carry_Out}, 32'h0);
    check_val({tag, "_v"},    {31'h0, Overflow_Out}, 32'h0);
    check_val({tag, "_ov"},   {31'h0, Out_Valid}, 32'h0);
    check_val({tag, "_busy"}, {31'h0, Busy}, 32'h0);
    check_val({tag, "_rdy"},  {31'h0, In_Ready}, 32'h1);
  endtask

  // Issue one op with Out_Ready held high, measure latency and check the result.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [2:0] op, input logic sh, input int exp_lat,
                        input logic [15:0] exp_res, input logic exp_c,
                        input logic exp_v, input logic exp_z);
    int lat;
    @(negedge Clk);
    Operand1 = a; Operand2 = b; Alu_Opcode = op; Shift = sh;
    Out_Ready = 1'b1; In_Valid = 1'b1;
    @(posedge Clk); #1;
    In_Valid = 1'b0;
    lat = 1;
    while (!Out_Valid && lat < 40) begin
      @(posedge Clk); #1;
      lat++;
    end
    check_val({tag, "_lat"}, lat, exp_lat);
    check_val({tag, "_res"}, {16'h0000, Result}, {16'h0000, exp_res});
    check_val({tag, "_c"},   {31'h0, Carry_Out}, {31'h0, exp_c});
    check_val({tag, "_v"},   {31'h0, Overflow_Out}, {31'h0, exp_v});
    check_val({tag, "_z"},   {31'h0, Zero_Out}, {31'h0, exp_z});
    @(posedge Clk); #1;
    check_val({tag, "_rdy"}, {31'h0, In_Ready}, 32'h1);
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    Reset_n = 1'b0; In_Valid = 1'b0; Out_Ready = 1'b0; Shift = 1'b0;
    Operand1 = 16'h0000; Operand2 = 16'h0000; Alu_Opcode = 3'b000;
    #12;
    check_reset_outputs("por");
    @(negedge Clk);
    Reset_n = 1'b1;

    //      tag      A         B         op      sh    lat res       c     v     z
    run_op("add_ovf", 16'h7FFF, 16'h0001, 3'b000, 1'b0, 1, 16'h8000, 1'b0, 1'b1, 1'b0);
    run_op("add_cry", 16'hFFFF, 16'h0001, 3'b000, 1'b0, 1, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_op("sub_eq",  16'h0005, 16'h0005, 3'b001, 1'b0, 1, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_op("sub_brw", 16'h0003, 16'h0005, 3'b001, 1'b0, 1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    run_op("sub_ovf", 16'h8000, 16'h0001, 3'b001, 1'b0, 1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    run_op("and",     16'hF0F0, 16'h3C3C, 3'b010, 1'b0, 1, 16'h3030, 1'b0, 1'b0, 1'b0);
    run_op("or",      16'hF000, 16'h000F, 3'b011, 1'b0, 1, 16'hF00F, 1'b0, 1'b0, 1'b0);
    run_op("xor",     16'hAAAA, 16'hAAAA, 3'b100, 1'b0, 1, 16'h0000, 1'b0, 1'b0, 1'b1);
    run_op("slt",     16'hFFFF, 16'h0001, 3'b101, 1'b0, 1, 16'h0001, 1'b0, 1'b0, 1'b0);
    run_op("sltu",    16'hFFFF, 16'h0001, 3'b110, 1'b0, 1, 16'h0000, 1'b0, 1'b0, 1'b1);
    run_op("sra3",    16'h8001, 16'h0013, 3'b010, 1'b1, 4, 16'hF000, 1'b0, 1'b0, 1'b0);
    run_op("sll0",    16'h1234, 16'h0010, 3'b000, 1'b1, 1, 16'h1234, 1'b0, 1'b0, 1'b0);
    run_op("sll4",    16'h1234, 16'h0004, 3'b000, 1'b1, 5, 16'h2340, 1'b1, 1'b0, 1'b0);
    run_op("srl2",    16'h0003, 16'h0002, 3'b001, 1'b1, 3, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_op("rol1",    16'h8001, 16'h0001, 3'b011, 1'b1, 2, 16'h0003, 1'b1, 1'b0, 1'b0);
    run_op("sra_op6", 16'h8000, 16'h0001, 3'b110, 1'b1, 2, 16'hC000, 1'b0, 1'b0, 1'b0);
`ifdef SEQ_ALU_MUL_EN
    run_op("mul",     16'h0123, 16'h0010, 3'b111, 1'b0, 17, 16'h1230, 1'b0, 1'b0, 1'b0);
    run_op("mul_wrap", 16'hFFFF, 16'hFFFF, 3'b111, 1'b0, 17, 16'h0001, 1'b0, 1'b0, 1'b0);
`else
    run_op("mul_off", 16'h0123, 16'h0010, 3'b111, 1'b0, 1, 16'h0000, 1'b0, 1'b0, 1'b1);
`endif

    // Back-pressure: result held, new bundle waits until the result is taken
    @(negedge Clk);
    Out_Ready = 1'b0;
    Operand1 = 16'h0010; Operand2 = 16'h0020; Alu_Opcode = 3'b000; Shift = 1'b0;
    In_Valid = 1'b1;
    @(posedge Clk); #1;
    Operand1 = 16'h00FF; Operand2 = 16'h0F0F; Alu_Opcode = 3'b100;
    check_val("hold_first_ov", {31'h0, Out_Valid}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk); #1;
      check_val("hold_res", {16'h0000, Result}, 32'h0000_0030);
      check_val("hold_rdy", {31'h0, In_Ready}, 32'h0);
      check_val("hold_ov",  {31'h0, Out_Valid}, 32'h1);
    end
    @(negedge Clk);
    Out_Ready = 1'b1;
    @(posedge Clk); #1;
    check_val("hold_release_rdy", {31'h0, In_Ready}, 32'h1);
    check_val("hold_release_ov",  {31'h0, Out_Valid}, 32'h0);
    @(posedge Clk); #1;
    In_Valid = 1'b0;
    check_val("hold_new_ov",  {31'h0, Out_Valid}, 32'h1);
    check_val("hold_new_res", {16'h0000, Result}, 32'h0000_0FF0);
    @(posedge Clk); #1;
    check_val("hold_new_rdy", {31'h0, In_Ready}, 32'h1);

    // Asynchronous reset in the middle of a multi-cycle op
    @(negedge Clk);
`ifdef SEQ_ALU_MUL_EN
    Operand1 = 16'h0123; Operand2 = 16'h0010; Alu_Opcode = 3'b111; Shift = 1'b0;
`else
    Operand1 = 16'h0001; Operand2 = 16'h000F; Alu_Opcode = 3'b000; Shift = 1'b1;
`endif
    In_Valid = 1'b1;
    @(posedge Clk); #1;
    In_Valid = 1'b0;
    check_val("mid_busy", {31'h0, Busy}, 32'h1);
    repeat (6) @(posedge Clk);
    #3;
    Reset_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    @(negedge Clk);
    Reset_n = 1'b1;
    run_op("post_rst_add", 16'h0002, 16'h0003, 3'b000, 1'b0, 1, 16'h0005, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
